// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds issued ops, wakes operands from the CDB,
// dispatches the lowest-index ready op and returns tagged results. Option: ALU_RS_SELF_WAKE_EN.
module alu_rs #(
  parameter int ROB_WIDTH = 4,
  parameter int RS_WIDTH  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 issue_valid,
  input  logic [3:0]           issue_op,
  input  logic [31:0]          issue_vj,
  input  logic [31:0]          issue_vk,
  input  logic [ROB_WIDTH-1:0] issue_qj,
  input  logic [ROB_WIDTH-1:0] issue_qk,
  input  logic                 issue_rj,
  input  logic                 issue_rk,
  input  logic [ROB_WIDTH-1:0] issue_rob,
  output logic                 rs_full,
  input  logic                 cdb_valid,
  input  logic [ROB_WIDTH-1:0] cdb_rob,
  input  logic [31:0]          cdb_value,
  output logic                 cal,
  output logic [31:0]          a,
  output logic [31:0]          b,
  output logic [3:0]           alu_op,
  output logic [RS_WIDTH-1:0]  to_alu_index,
  input  logic                 alu_done,
  input  logic [RS_WIDTH-1:0]  alu_index,
  input  logic [31:0]          alu_result,
  output logic                 out_valid,
  output logic [ROB_WIDTH-1:0] out_rob,
  output logic [31:0]          out_value
);

  localparam int N = 1 << RS_WIDTH;

  logic                 busy_q   [N];
  logic                 busy_d   [N];
  logic                 issued_q [N];
  logic                 issued_d [N];
  logic [3:0]           op_q     [N];
  logic [3:0]           op_d     [N];
  logic [31:0]          vj_q     [N];
  logic [31:0]          vj_d     [N];
  logic [31:0]          vk_q     [N];
  logic [31:0]          vk_d     [N];
  logic                 rj_q     [N];
  logic                 rj_d     [N];
  logic                 rk_q     [N];
  logic                 rk_d     [N];
  logic [ROB_WIDTH-1:0] qj_q     [N];
  logic [ROB_WIDTH-1:0] qj_d     [N];
  logic [ROB_WIDTH-1:0] qk_q     [N];
  logic [ROB_WIDTH-1:0] qk_d     [N];
  logic [ROB_WIDTH-1:0] rob_q    [N];
  logic [ROB_WIDTH-1:0] rob_d    [N];

  logic                 out_valid_q, out_valid_d;
  logic [ROB_WIDTH-1:0] out_rob_q, out_rob_d;
  logic [31:0]          out_value_q, out_value_d;

  logic [RS_WIDTH-1:0]  free_idx, sel_idx;
  logic                 has_ready, full;
  logic [ROB_WIDTH-1:0] done_rob;
  logic                 self_wake;

`ifdef ALU_RS_SELF_WAKE_EN
  assign self_wake = alu_done;
`else
  assign self_wake = 1'b0;
`endif

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    free_idx  = '0;
    sel_idx   = '0;
    has_ready = 1'b0;
    full      = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = RS_WIDTH'(i);
        full     = 1'b0;
      end
      if (busy_q[i] && !issued_q[i] && rj_q[i] && rk_q[i]) begin
        sel_idx   = RS_WIDTH'(i);
        has_ready = 1'b1;
      end
    end
  end

  assign done_rob     = rob_q[alu_index];
  assign rs_full      = full;
  assign cal          = rdy_in && !clear && has_ready;
  assign a            = vj_q[sel_idx];
  assign b            = vk_q[sel_idx];
  assign alu_op       = op_q[sel_idx];
  assign to_alu_index = sel_idx;
  assign out_valid    = out_valid_q;
  assign out_rob      = out_rob_q;
  assign out_value    = out_value_q;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      busy_d[i]   = busy_q[i];
      issued_d[i] = issued_q[i];
      op_d[i]     = op_q[i];
      vj_d[i]     = vj_q[i];
      vk_d[i]     = vk_q[i];
      rj_d[i]     = rj_q[i];
      rk_d[i]     = rk_q[i];
      qj_d[i]     = qj_q[i];
      qk_d[i]     = qk_q[i];
      rob_d[i]    = rob_q[i];
    end
    out_valid_d = out_valid_q;
    out_rob_d   = out_rob_q;
    out_value_d = out_value_q;

    if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < N; i++) begin
          busy_d[i]   = 1'b0;
          issued_d[i] = 1'b0;
        end
        out_valid_d = 1'b0;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (busy_q[i] && !rj_q[i]) begin
            if (cdb_valid && qj_q[i] == cdb_rob) begin
              vj_d[i] = cdb_value;
              rj_d[i] = 1'b1;
            end
            if (self_wake && qj_q[i] == done_rob) begin
              vj_d[i] = alu_result;
              rj_d[i] = 1'b1;
            end
          end
          if (busy_q[i] && !rk_q[i]) begin
            if (cdb_valid && qk_q[i] == cdb_rob) begin
              vk_d[i] = cdb_value;
              rk_d[i] = 1'b1;
            end
            if (self_wake && qk_q[i] == done_rob) begin
              vk_d[i] = alu_result;
              rk_d[i] = 1'b1;
            end
          end
        end

        if (cal) issued_d[sel_idx] = 1'b1;

        out_valid_d = alu_done;
        if (alu_done) begin
          busy_d[alu_index]   = 1'b0;
          issued_d[alu_index] = 1'b0;
          out_rob_d           = done_rob;
          out_value_d         = alu_result;
        end

        // A free entry is never the completing one, so this cannot collide with the free above.
        if (issue_valid && !full) begin
          busy_d[free_idx]   = 1'b1;
          issued_d[free_idx] = 1'b0;
          op_d[free_idx]     = issue_op;
          rob_d[free_idx]    = issue_rob;
          vj_d[free_idx]     = issue_vj;
          rj_d[free_idx]     = issue_rj;
          qj_d[free_idx]     = issue_qj;
          vk_d[free_idx]     = issue_vk;
          rk_d[free_idx]     = issue_rk;
          qk_d[free_idx]     = issue_qk;
          if (!issue_rj && cdb_valid && issue_qj == cdb_rob) begin
            vj_d[free_idx] = cdb_value;
            rj_d[free_idx] = 1'b1;
          end
          if (!issue_rj && self_wake && issue_qj == done_rob) begin
            vj_d[free_idx] = alu_result;
            rj_d[free_idx] = 1'b1;
          end
          if (!issue_rk && cdb_valid && issue_qk == cdb_rob) begin
            vk_d[free_idx] = cdb_value;
            rk_d[free_idx] = 1'b1;
          end
          if (!issue_rk && self_wake && issue_qk == done_rob) begin
            vk_d[free_idx] = alu_result;
            rk_d[free_idx] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        busy_q[i]   <= 1'b0;
        issued_q[i] <= 1'b0;
        op_q[i]     <= '0;
        vj_q[i]     <= '0;
        vk_q[i]     <= '0;
        rj_q[i]     <= 1'b0;
        rk_q[i]     <= 1'b0;
        qj_q[i]     <= '0;
        qk_q[i]     <= '0;
        rob_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_value_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        busy_q[i]   <= busy_d[i];
        issued_q[i] <= issued_d[i];
        op_q[i]     <= op_d[i];
        vj_q[i]     <= vj_d[i];
        vk_q[i]     <= vk_d[i];
        rj_q[i]     <= rj_d[i];
        rk_q[i]     <= rk_d[i];
        qj_q[i]     <= qj_d[i];
        qk_q[i]     <= qk_d[i];
        rob_q[i]    <= rob_d[i];
      end
      out_valid_q <= out_valid_d;
      out_rob_q   <= out_rob_d;
      out_value_q <= out_value_d;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a vector table for single-op flows plus hand sequences
// for fill/wake ordering, flush, freeze, reset and the ALU_RS_SELF_WAKE_EN option.
module tb_alu_rs;

  logic        clk_in, rst_in, rdy_in, clear;
  logic        issue_valid, issue_rj, issue_rk;
  logic [3:0]  issue_op, issue_qj, issue_qk, issue_rob;
  logic [31:0] issue_vj, issue_vk;
  logic        rs_full, cdb_valid, cal, alu_done, out_valid;
  logic [3:0]  cdb_rob, alu_op, out_rob;
  logic [31:0] cdb_value, a, b, alu_result, out_value;
  logic [1:0]  to_alu_index, alu_index;

  int testsRun = 0;
  int failures = 0;

  typedef struct packed {
    logic        rdy, clr, iv;
    logic [3:0]  op;
    logic [31:0] vj, vk;
    logic [3:0]  qj, qk;
    logic        rj, rk;
    logic [3:0]  rob;
    logic        cv;
    logic [3:0]  crob;
    logic [31:0] cval;
    logic        ad;
    logic [1:0]  aidx;
    logic [31:0] ares;
    logic        eFull, eCal;
    logic [31:0] eA, eB;
    logic [3:0]  eOp;
    logic [1:0]  eIdx;
    logic        eOv;
    logic [3:0]  eRob;
    logic [31:0] eVal;
  } vec_t;

  vec_t vecs[$];

  alu_rs #(.ROB_WIDTH(4), .RS_WIDTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_rj(issue_rj), .issue_rk(issue_rk),
    .issue_rob(issue_rob), .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_value(cdb_value), .cal(cal), .a(a), .b(b), .alu_op(alu_op),
    .to_alu_index(to_alu_index), .alu_done(alu_done), .alu_index(alu_index),
    .alu_result(alu_result), .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic vec_t mk();
    vec_t v;
    v = '0;
    v.rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t withIssue(vec_t v, logic [3:0] op, logic [31:0] vj, logic rj,
                                     logic [3:0] qj, logic [31:0] vk, logic rk,
                                     logic [3:0] qk, logic [3:0] rob);
    v.iv = 1'b1; v.op = op; v.vj = vj; v.rj = rj; v.qj = qj;
    v.vk = vk; v.rk = rk; v.qk = qk; v.rob = rob;
    return v;
  endfunction

  function automatic vec_t withCdb(vec_t v, logic [3:0] rob, logic [31:0] val);
    v.cv = 1'b1; v.crob = rob; v.cval = val;
    return v;
  endfunction

  function automatic vec_t withDone(vec_t v, logic [1:0] idx, logic [31:0] res);
    v.ad = 1'b1; v.aidx = idx; v.ares = res;
    return v;
  endfunction

  function automatic vec_t expCal(vec_t v, logic [1:0] idx, logic [31:0] ea, logic [31:0] eb,
                                  logic [3:0] op);
    v.eCal = 1'b1; v.eIdx = idx; v.eA = ea; v.eB = eb; v.eOp = op;
    return v;
  endfunction

  function automatic vec_t expOut(vec_t v, logic [3:0] rob, logic [31:0] val);
    v.eOv = 1'b1; v.eRob = rob; v.eVal = val;
    return v;
  endfunction

  function automatic vec_t expFull(vec_t v);
    v.eFull = 1'b1;
    return v;
  endfunction

  function automatic vec_t frozen(vec_t v);
    v.rdy = 1'b0;
    return v;
  endfunction

  function automatic vec_t flush(vec_t v);
    v.clr = 1'b1;
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    if (v.iv && v.rdy && !v.clr) checkVal({name, ".issue_while_full"}, 32'(rs_full), 32'd0);
    rdy_in      = v.rdy;
    clear       = v.clr;
    issue_valid = v.iv;
    issue_op    = v.op;
    issue_vj    = v.vj;
    issue_vk    = v.vk;
    issue_qj    = v.qj;
    issue_qk    = v.qk;
    issue_rj    = v.rj;
    issue_rk    = v.rk;
    issue_rob   = v.rob;
    cdb_valid   = v.cv;
    cdb_rob     = v.crob;
    cdb_value   = v.cval;
    alu_done    = v.ad;
    alu_index   = v.aidx;
    alu_result  = v.ares;
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    checkVal({name, ".rs_full"}, 32'(rs_full), 32'(v.eFull));
    checkVal({name, ".cal"}, 32'(cal), 32'(v.eCal));
    if (v.eCal) begin
      checkVal({name, ".a"}, a, v.eA);
      checkVal({name, ".b"}, b, v.eB);
      checkVal({name, ".alu_op"}, 32'(alu_op), 32'(v.eOp));
      checkVal({name, ".to_alu_index"}, 32'(to_alu_index), 32'(v.eIdx));
    end
    checkVal({name, ".out_valid"}, 32'(out_valid), 32'(v.eOv));
    if (v.eOv) begin
      checkVal({name, ".out_rob"}, 32'(out_rob), 32'(v.eRob));
      checkVal({name, ".out_value"}, out_value, v.eVal);
    end
  endtask

  // Drive on the falling edge, sample 2 time units later, state updates on the next rising edge.
  task automatic runVector(input string name, input vec_t v);
    @(negedge clk_in);
    applyStimulus(v, name);
    #2;
    checkOutput(v, name);
  endtask

  initial begin
    vec_t v;
    rst_in = 1'b1;
    applyStimulus(mk(), "init");
    repeat (2) @(negedge clk_in);
    #2;
    checkOutput(mk(), "reset");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Ready ADD, CDB-woken SUB (late and same-cycle), k-operand wake, back-to-back throughput.
    vecs.push_back(withIssue(mk(), 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 4'd3));
    vecs.push_back(expCal(mk(), 2'd0, 32'd5, 32'd7, 4'd0));
    vecs.push_back(withDone(mk(), 2'd0, 32'd12));
    vecs.push_back(expOut(mk(), 4'd3, 32'd12));
    vecs.push_back(withIssue(mk(), 4'd1, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0, 4'd2));
    vecs.push_back(withCdb(mk(), 4'd6, 32'd10));
    vecs.push_back(expCal(mk(), 2'd0, 32'd10, 32'd1, 4'd1));
    vecs.push_back(withDone(mk(), 2'd0, 32'd9));
    vecs.push_back(expOut(mk(), 4'd2, 32'd9));
    vecs.push_back(withCdb(withIssue(mk(), 4'd1, 32'd0, 1'b0, 4'd6, 32'd1, 1'b1, 4'd0, 4'd5),
                           4'd6, 32'd10));
    vecs.push_back(expCal(mk(), 2'd0, 32'd10, 32'd1, 4'd1));
    vecs.push_back(withDone(mk(), 2'd0, 32'd9));
    vecs.push_back(expOut(mk(), 4'd5, 32'd9));
    vecs.push_back(withIssue(mk(), 4'd0, 32'd100, 1'b1, 4'd0, 32'd0, 1'b0, 4'd9, 4'd7));
    vecs.push_back(withCdb(mk(), 4'd8, 32'd55));
    v = withCdb(mk(), 4'd9, 32'd66);
    v.cv = 1'b0;
    vecs.push_back(v);
    vecs.push_back(withCdb(mk(), 4'd9, 32'd23));
    vecs.push_back(expCal(mk(), 2'd0, 32'd100, 32'd23, 4'd0));
    vecs.push_back(withDone(mk(), 2'd0, 32'd123));
    vecs.push_back(expOut(mk(), 4'd7, 32'd123));
    vecs.push_back(withIssue(mk(), 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd10));
    vecs.push_back(expCal(withIssue(mk(), 4'd1, 32'd20, 1'b1, 4'd0, 32'd3, 1'b1, 4'd0, 4'd11),
                          2'd0, 32'd1, 32'd2, 4'd0));
    vecs.push_back(expCal(withDone(mk(), 2'd0, 32'd3), 2'd1, 32'd20, 32'd3, 4'd1));
    vecs.push_back(expOut(withDone(mk(), 2'd1, 32'd17), 4'd10, 32'd3));
    vecs.push_back(expOut(mk(), 4'd11, 32'd17));

    for (int i = 0; i < vecs.size(); i++) runVector($sformatf("vec%0d", i), vecs[i]);

    // Fill with unready ops; entries 1 and 3 share a producer tag and wake together.
    runVector("fill0", withIssue(mk(), 4'd2, 32'd0, 1'b0, 4'd10, 32'd1, 1'b1, 4'd0, 4'd1));
    runVector("fill1", withIssue(mk(), 4'd2, 32'd0, 1'b0, 4'd11, 32'd2, 1'b1, 4'd0, 4'd2));
    runVector("fill2", withIssue(mk(), 4'd2, 32'd0, 1'b0, 4'd12, 32'd3, 1'b1, 4'd0, 4'd3));
    runVector("fill3", withIssue(mk(), 4'd2, 32'd0, 1'b0, 4'd11, 32'd4, 1'b1, 4'd0, 4'd4));
    runVector("full", expFull(mk()));
    runVector("wake2", expFull(withCdb(mk(), 4'd11, 32'd50)));
    runVector("order1", expFull(expCal(mk(), 2'd1, 32'd50, 32'd2, 4'd2)));
    runVector("order3", expFull(expCal(withDone(mk(), 2'd1, 32'd52), 2'd3, 32'd50, 32'd4, 4'd2)));
    runVector("unfull", expOut(withDone(mk(), 2'd3, 32'd54), 4'd2, 32'd52));
    runVector("done3", expOut(mk(), 4'd4, 32'd54));

    // Flush with two entries in flight and a completion in the same cycle.
    runVector("wake0", withCdb(mk(), 4'd10, 32'd1));
    runVector("wake2b", expCal(withCdb(mk(), 4'd12, 32'd2), 2'd0, 32'd1, 32'd1, 4'd2));
    runVector("flush", flush(withDone(mk(), 2'd0, 32'd2)));
    runVector("postflush", withIssue(mk(), 4'd0, 32'd7, 1'b1, 4'd0, 32'd8, 1'b1, 4'd0, 4'd9));
    runVector("reuse0", expCal(mk(), 2'd0, 32'd7, 32'd8, 4'd0));
    runVector("noghost", withDone(mk(), 2'd0, 32'd15));
    runVector("flushout", expOut(mk(), 4'd9, 32'd15));

    // Freeze for 3 cycles while a dispatch is pending; everything driven is ignored.
    runVector("frz.issue", withIssue(mk(), 4'd3, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd6));
    for (int i = 0; i < 3; i++)
      runVector($sformatf("frz%0d", i),
                frozen(withDone(withCdb(withIssue(mk(), 4'd0, 32'd99, 1'b1, 4'd0, 32'd99, 1'b1,
                                                  4'd0, 4'd8), 4'd6, 32'd5), 2'd0, 32'd77)));
    runVector("frz.resume", expCal(mk(), 2'd0, 32'd3, 32'd4, 4'd3));
    runVector("frz.done", withDone(mk(), 2'd0, 32'd7));
    runVector("frz.out", frozen(expOut(mk(), 4'd6, 32'd7)));
    runVector("frz.outhold", expOut(mk(), 4'd6, 32'd7));
    runVector("frz.outend", mk());

    // Asynchronous reset with three busy entries and a dispatch showing.
    runVector("rst.p0", withIssue(mk(), 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 1'b1, 4'd0, 4'd3));
    runVector("rst.p1", expCal(withIssue(mk(), 4'd0, 32'd0, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0, 4'd4),
                               2'd0, 32'd1, 32'd2, 4'd0));
    runVector("rst.p2", withDone(withIssue(mk(), 4'd0, 32'd0, 1'b0, 4'd15, 32'd0, 1'b1, 4'd0,
                                           4'd5), 2'd0, 32'd3));
    runVector("rst.p3", expOut(withIssue(mk(), 4'd0, 32'd5, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd6),
                               4'd3, 32'd3));
    runVector("rst.p4", expCal(mk(), 2'd0, 32'd5, 32'd6, 4'd0));
    #1 rst_in = 1'b1;
    #1;
    checkVal("rst.async.cal", 32'(cal), 32'd0);
    checkVal("rst.async.rs_full", 32'(rs_full), 32'd0);
    checkVal("rst.async.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    runVector("rst.q0", mk());
    runVector("rst.q1", withCdb(mk(), 4'd15, 32'd1));
    runVector("rst.q2", mk());

    // Dependent op on an ALU result; self-wake skips the CDB round trip.
    runVector("sw.s0", withIssue(mk(), 4'd0, 32'd4, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 4'd1));
    runVector("sw.s1", expCal(withIssue(mk(), 4'd1, 32'd0, 1'b0, 4'd1, 32'd1, 1'b1, 4'd0, 4'd2),
                              2'd0, 32'd4, 32'd6, 4'd0));
    runVector("sw.s2", withDone(mk(), 2'd0, 32'd10));
`ifdef ALU_RS_SELF_WAKE_EN
    runVector("sw.s3", expCal(expOut(mk(), 4'd1, 32'd10), 2'd1, 32'd10, 32'd1, 4'd1));
    runVector("sw.s4", withDone(mk(), 2'd1, 32'd9));
    runVector("sw.s5", expOut(mk(), 4'd2, 32'd9));
`else
    runVector("sw.s3", expOut(mk(), 4'd1, 32'd10));
    runVector("sw.s4", withCdb(mk(), 4'd1, 32'd10));
    runVector("sw.s5", expCal(mk(), 2'd1, 32'd10, 32'd1, 4'd1));
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
